// File: rtl/membus_master_if.sv
// Memory bus signal bundle between the initiator (membus_master) and a
// memory slave: Avalon-MM style request/response with waitrequest stall.
interface membus_master_if;
    logic [17:0] o_address;
    logic        o_read;
    logic        o_write;
    logic [35:0] o_writedata;
    logic [35:0] i_readdata;
    logic        i_waitrequest;

    modport master (
        output o_address,
        output o_read,
        output o_write,
        output o_writedata,
        input  i_readdata,
        input  i_waitrequest
    );

    modport slave (
        input  o_address,
        input  o_read,
        input  o_write,
        input  o_writedata,
        output i_readdata,
        output i_waitrequest
    );
endinterface

// File: rtl/membus_master.sv
// Initiator side of the 36-bit word memory bus. Runs PDP-6 style read,
// write and read-modify-write (with restart) memory cycles as bus transfers
// that honour waitrequest. A transfer stalled for TIMEOUT consecutive edges
// is dropped and reported as nonexistent memory.
module membus_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_rd,
    input  logic               i_wr,
    input  logic [17:0]        i_addr,
    input  logic [35:0]        i_wdata,
    input  logic               i_wr_rs,
    output logic               o_busy,
    output logic [35:0]        o_rdata,
    output logic               o_rd_done,
    output logic               o_done,
    output logic               o_nxm,
    membus_master_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        RWAIT = 2'd2,
        WR    = 2'd3
    } state_t;

    localparam logic [CW:0] TMAX = TIMEOUT[CW:0];

    state_t      state_q, state_d;
    logic [17:0] addr_q, addr_d;
    logic [35:0] wdata_q, wdata_d;
    logic [35:0] rdata_q, rdata_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d;
    logic        rd_done_q, rd_done_d;
    logic        done_q, done_d;
    logic        nxm_q, nxm_d;
    logic        wrflag_q, wrflag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0] cnt_inc;
    logic        xfer_done;
    logic        stall_limit;

    assign cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign xfer_done   = (read_q | write_q) & ~bus.i_waitrequest;
    // This stalled edge would be the TIMEOUT-th one; completion is checked first.
    assign stall_limit = (cnt_inc == TMAX);

    // State and registered outputs; async reset drops the bus request at once.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            rd_done_q <= 1'b0;
            done_q    <= 1'b0;
            nxm_q     <= 1'b0;
            wrflag_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            rd_done_q <= rd_done_d;
            done_q    <= done_d;
            nxm_q     <= nxm_d;
            wrflag_q  <= wrflag_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and next-output logic for the memory cycle sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        read_d    = read_q;
        write_d   = write_q;
        wrflag_d  = wrflag_q;
        cnt_d     = cnt_q;
        rd_done_d = 1'b0;
        done_d    = 1'b0;
        nxm_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start && (i_rd || i_wr)) begin
                    addr_d   = i_addr;
                    wrflag_d = i_wr;
                    cnt_d    = '0;
                    if (i_rd) begin
                        read_d  = 1'b1;
                        state_d = RD;
                    end else begin
                        wdata_d = i_wdata;
                        write_d = 1'b1;
                        state_d = WR;
                    end
                end
            end
            RD: begin
                if (xfer_done) begin
                    rdata_d   = bus.i_readdata;
                    read_d    = 1'b0;
                    rd_done_d = 1'b1;
                    if (wrflag_q) begin
                        state_d = RWAIT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (stall_limit) begin
                    read_d  = 1'b0;
                    nxm_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            RWAIT: begin
                if (i_wr_rs) begin
                    wdata_d = i_wdata;
                    write_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WR;
                end
            end
            WR: begin
                if (xfer_done) begin
                    write_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (stall_limit) begin
                    write_d = 1'b0;
                    nxm_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign o_busy          = busy_q;
    assign o_rdata         = rdata_q;
    assign o_rd_done       = rd_done_q;
    assign o_done          = done_q;
    assign o_nxm           = nxm_q;
    assign bus.o_address   = addr_q;
    assign bus.o_read      = read_q;
    assign bus.o_write     = write_q;
    assign bus.o_writedata = wdata_q;

endmodule

// File: doc/membus_master.md
# membus_master

Initiator side of the 36-bit word memory bus. Accepts PDP-6 style memory cycle requests (read, write, read-modify-write with restart) from the processor. Drives them as Avalon-MM style transfers to a memory slave, honouring waitrequest. Aborts with a nonexistent-memory indication when the slave never responds.

## Interface
Parameters:
- TIMEOUT, 255, consecutive stalled cycles (waitrequest high during a transfer) before abort; legal 1..65535
- CW, $clog2(TIMEOUT+1), timeout counter width (derived; do not override)

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle request strobe; sampled only in IDLE
- i_rd  in  1  cycle includes read phase
- i_wr  in  1  cycle includes write phase
- i_addr  in  18  word address, latched on accepted i_start
- i_wdata  in  36  write data, latched on accepted i_start (write-only) or on i_wr_rs (RMW)
- i_wr_rs  in  1  write restart strobe for RMW; sampled only in RWAIT
- o_busy  out  1  high whenever state != IDLE
- o_rdata  out  36  read data, holds until next read completes
- o_rd_done  out  1  one-cycle pulse: o_rdata updated
- o_done  out  1  one-cycle pulse: memory cycle complete
- o_nxm  out  1  one-cycle pulse: cycle aborted on timeout
- o_address  out  18  bus address
- o_read  out  1  bus read request
- o_write  out  1  bus write request
- o_writedata  out  36  bus write data
- i_readdata  in  36  bus read data, valid on completion edge
- i_waitrequest  in  1  bus stall

## Operation
- All outputs registered. Reset clears every output to 0 and state to IDLE.
- Bus transfer completes on a rising edge where (o_read|o_write) & !i_waitrequest.
- States:
  - IDLE: on i_start, latch i_addr into o_address and latch rd/wr flags.
    - i_rd set: go RD and set o_read.
    - Else i_wr set: latch i_wdata into o_writedata, go WR and set o_write.
    - Neither set: stay IDLE, no response.
  - RD: on completion, capture i_readdata into o_rdata, clear o_read, pulse o_rd_done.
    - Flag wr set: go RWAIT.
    - Else: pulse o_done and go IDLE.
  - RWAIT: no bus request. On i_wr_rs, latch i_wdata into o_writedata, set o_write, go WR. Waits indefinitely; no timeout applies.
  - WR: on completion, clear o_write, pulse o_done, go IDLE.
- Timeout:
  - Counter clears on entry to RD or WR and increments each RD/WR edge with i_waitrequest high.
  - When the count reaches TIMEOUT, clear o_read/o_write, pulse o_nxm, go IDLE.
  - A timeout produces no o_rd_done and no o_done.
  - In RMW, a write-phase timeout follows a read phase that already pulsed o_rd_done.
- i_start while busy and i_wr_rs outside RWAIT are ignored; no queuing.
- o_read and o_write are never high together.
- o_address and o_writedata are stable for the whole time o_read/o_write is high.

## Timing
- i_start sampled at edge T: o_read/o_write and o_busy high from T; the first possible completion is edge T+1.
- Against a slave whose waitrequest is registered from its request inputs (drops one cycle after it sees the request), completion occurs at T+2.
- o_rd_done and o_done go high on the completion edge and last exactly one cycle. o_rdata is valid from that edge.
- Read cycle: o_busy drops on the completion edge (o_done coincident).
- RMW: o_busy stays high through RWAIT.
  - i_wr_rs at edge W raises o_write at W.
  - A new i_start is accepted on the edge after o_done.
- Timeout: exactly TIMEOUT stalled edges after request assertion, o_nxm pulses and o_read/o_write fall on that edge.
- If waitrequest drops on the same edge the count reaches TIMEOUT, completion wins and o_nxm is not pulsed.
- Reset asserted mid-transfer drops o_read/o_write immediately (asynchronous); no done/nxm pulse is produced.

## Test plan
- Read: start rd=1 addr=0o000005 with slave word 0o123456701234. Required: o_read high from T for 2 cycles, o_rdata=0o123456701234 and o_rd_done+o_done at T+2, o_busy low at T+2.
- Write: start wr=1 addr=3 wdata=0o777777000000. Required: o_write high 2 cycles with o_address=3 and o_writedata=0o777777000000, o_done at T+2, and a read-back returns the word.
- RMW: start rd=wr=1 addr=7. Required: o_rd_done, then hold RWAIT 10 cycles with o_busy=1 and no bus request; i_wr_rs with wdata=5 then produces a write of 5 to addr 7 and o_done; no o_done before the write.
- Timeout with TIMEOUT=4: start rd to an address the slave holds stalled (waitrequest stuck high). Required: o_nxm pulse exactly 4 edges after request, o_read low, no o_rd_done/o_done; a following start is accepted.
- Ignored inputs: i_start during RD and i_wr_rs in IDLE. Required: no effect on state, address or data; start with rd=wr=0 produces no bus activity.
- Async reset asserted while o_write high. Required: all outputs 0 immediately without a clock edge; after release, a normal read completes.
